// File: rtl/ms_pkg.sv
// ----------------------------------------------------------------------------
// ms_pkg
//   Shared definitions for the Minesweeper player-side judge:
//   - cond encodings reported to the game-state FSM
//   - judge FSM state encoding
//   - popcount helper used to size the safe-cell counter at game load
// Configuration macro used by the files importing this package:
//   MOVE_JUDGE_FLAG_EN
// ----------------------------------------------------------------------------
package ms_pkg;

    localparam logic [1:0] COND_PLAY = 2'b00;
    localparam logic [1:0] COND_WIN  = 2'b01;
    localparam logic [1:0] COND_LOSE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_MOVE = 3'd2,
        ST_CHECK     = 3'd3,
        ST_UPDATE    = 3'd4,
        ST_OVER      = 3'd5
    } judge_state_e;

    // Widest board the popcount helper accepts; callers zero-extend.
    localparam int MAX_CELLS = 256;

    function automatic int unsigned popcount(input logic [MAX_CELLS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_CELLS; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/move_judge_if.sv
// ----------------------------------------------------------------------------
// move_judge_if
//   Groups the player/board signals of move_judge.
//   master modport : environment side (drives buttons, new_game, mine_map,
//                    game_done; observes judge outputs)
//   slave modport  : move_judge side
//   Signals:
//     new_game, mine_map[CELLS]             board load request + mine bitmap
//     btn_up/down/left/right/reveal         synchronised level buttons
//     game_done                             done flag from the game-state FSM
//     cond[2], play_again                   outputs to the game-state FSM
//     cursor_row, cursor_col, revealed      board view
//   With MOVE_JUDGE_FLAG_EN defined: btn_flag (in), flagged[CELLS] (out).
// ----------------------------------------------------------------------------
interface move_judge_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    localparam int CELLS = ROWS * COLS;

    logic                    new_game;
    logic [CELLS-1:0]        mine_map;
    logic                    btn_up;
    logic                    btn_down;
    logic                    btn_left;
    logic                    btn_right;
    logic                    btn_reveal;
    logic                    game_done;
    logic [1:0]              cond;
    logic                    play_again;
    logic [$clog2(ROWS)-1:0] cursor_row;
    logic [$clog2(COLS)-1:0] cursor_col;
    logic [CELLS-1:0]        revealed;
`ifdef MOVE_JUDGE_FLAG_EN
    logic                    btn_flag;
    logic [CELLS-1:0]        flagged;
`endif

    modport master (
`ifdef MOVE_JUDGE_FLAG_EN
        output btn_flag,
        input  flagged,
`endif
        output new_game, mine_map, btn_up, btn_down, btn_left, btn_right,
        output btn_reveal, game_done,
        input  cond, play_again, cursor_row, cursor_col, revealed
    );

    modport slave (
`ifdef MOVE_JUDGE_FLAG_EN
        input  btn_flag,
        output flagged,
`endif
        input  new_game, mine_map, btn_up, btn_down, btn_left, btn_right,
        input  btn_reveal, game_done,
        output cond, play_again, cursor_row, cursor_col, revealed
    );

endinterface

// File: rtl/btn_edge.sv
// ----------------------------------------------------------------------------
// btn_edge
//   Rising-edge detector for one already-synchronised button. A single
//   register holds last cycle's level; rise is high during the cycle in
//   which the button first reads 1, so the judge acts on it at the next
//   clock edge.
//   Ports: clk, rst (async, active-low), btn (level in), rise (edge out)
// ----------------------------------------------------------------------------
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);
    logic btn_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) btn_q <= 1'b0;
        else      btn_q <= btn;
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/move_judge.sv
// ----------------------------------------------------------------------------
// move_judge
//   Player-side counterpart of the Minesweeper game-state FSM. Turns button
//   presses into cursor moves and cell reveals, tracks the revealed map and
//   the number of safe cells still hidden, and reports cond (00 play,
//   01 win, 11 lose) plus a one-cycle play_again restart request.
//   Ports:
//     clk  system clock
//     rst  asynchronous active-low reset
//     bus  move_judge_if.slave (buttons, new_game/mine_map, game_done in;
//          cond, play_again, cursor_row/col, revealed out)
//   Optional feature macro: MOVE_JUDGE_FLAG_EN (btn_flag input, flagged
//   bitmap output; flagged cells cannot be revealed).
// ----------------------------------------------------------------------------
module move_judge
    import ms_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic        clk,
    input  logic        rst,
    move_judge_if.slave bus
);
    localparam int CELLS  = ROWS * COLS;
    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int IDX_W  = $clog2(CELLS);
    localparam int SAFE_W = $clog2(CELLS + 1);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

    judge_state_e      state;
    logic [CELLS-1:0]  mines;
    logic [CELLS-1:0]  revealed_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [1:0]        cond_q;
    logic              play_again_q;
    logic [SAFE_W-1:0] safe_left;

    logic rise_up, rise_down, rise_left, rise_right, rise_reveal;
    logic rise_flag;
    logic cur_flagged;
    logic [IDX_W-1:0] cur_idx;

    assign cur_idx = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);

    btn_edge u_edge_up     (.clk(clk), .rst(rst), .btn(bus.btn_up),     .rise(rise_up));
    btn_edge u_edge_down   (.clk(clk), .rst(rst), .btn(bus.btn_down),   .rise(rise_down));
    btn_edge u_edge_left   (.clk(clk), .rst(rst), .btn(bus.btn_left),   .rise(rise_left));
    btn_edge u_edge_right  (.clk(clk), .rst(rst), .btn(bus.btn_right),  .rise(rise_right));
    btn_edge u_edge_reveal (.clk(clk), .rst(rst), .btn(bus.btn_reveal), .rise(rise_reveal));

`ifdef MOVE_JUDGE_FLAG_EN
    logic [CELLS-1:0] flagged_q;

    btn_edge u_edge_flag (.clk(clk), .rst(rst), .btn(bus.btn_flag), .rise(rise_flag));

    assign cur_flagged = flagged_q[cur_idx];

    // Flag toggles only when reveal is not also pressed (reveal wins) and
    // never on an already revealed cell.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flagged_q <= '0;
        end else if (!bus.new_game) begin
            if (state == ST_LOAD) begin
                flagged_q <= '0;
            end else if (state == ST_WAIT_MOVE && !rise_reveal && rise_flag
                         && !revealed_q[cur_idx]) begin
                flagged_q[cur_idx] <= ~flagged_q[cur_idx];
            end
        end
    end

    assign bus.flagged = flagged_q;
`else
    assign rise_flag   = 1'b0;
    assign cur_flagged = 1'b0;
`endif

    // NOTE: the mine and revealed bitmaps are plain flops, not a RAM, so they
    // take the asynchronous reset along with the rest of the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            mines        <= '0;
            revealed_q   <= '0;
            row_q        <= '0;
            col_q        <= '0;
            cond_q       <= COND_PLAY;
            play_again_q <= 1'b0;
            safe_left    <= '0;
        end else begin
            play_again_q <= 1'b0;
            if (bus.new_game) begin
                // A new game overrides everything, from any state.
                mines <= bus.mine_map;
                state <= ST_LOAD;
            end else begin
                unique case (state)
                    ST_IDLE: ;

                    ST_LOAD: begin
                        revealed_q <= '0;
                        row_q      <= '0;
                        col_q      <= '0;
                        cond_q     <= COND_PLAY;
                        safe_left  <= SAFE_W'(CELLS - popcount(MAX_CELLS'(mines)));
                        state      <= ST_WAIT_MOVE;
                    end

                    ST_WAIT_MOVE: begin
                        // One action per cycle: reveal > flag > up > down > left > right.
                        if (rise_reveal) begin
                            if (!cur_flagged) state <= ST_CHECK;
                        end else if (rise_flag) begin
                            // handled by the flag bitmap; cursor holds
                        end else if (rise_up) begin
                            if (row_q != '0) row_q <= row_q - 1'b1;
                        end else if (rise_down) begin
                            if (row_q != ROW_MAX) row_q <= row_q + 1'b1;
                        end else if (rise_left) begin
                            if (col_q != '0) col_q <= col_q - 1'b1;
                        end else if (rise_right) begin
                            if (col_q != COL_MAX) col_q <= col_q + 1'b1;
                        end
                    end

                    ST_CHECK: begin
                        if (mines[cur_idx]) begin
                            cond_q <= COND_LOSE;
                            state  <= ST_OVER;
                        end else if (revealed_q[cur_idx]) begin
                            state <= ST_WAIT_MOVE;
                        end else begin
                            revealed_q[cur_idx] <= 1'b1;
                            safe_left           <= safe_left - 1'b1;
                            state               <= ST_UPDATE;
                        end
                    end

                    ST_UPDATE: begin
                        // An empty mine map is a trivial board: any safe
                        // reveal wins it outright.
                        if (safe_left == '0 || mines == '0) begin
                            cond_q <= COND_WIN;
                            state  <= ST_OVER;
                        end else begin
                            state <= ST_WAIT_MOVE;
                        end
                    end

                    ST_OVER: begin
                        if (rise_reveal && bus.game_done) begin
                            play_again_q <= 1'b1;
                            cond_q       <= COND_PLAY;
                            state        <= ST_IDLE;
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.cond       = cond_q;
    assign bus.play_again = play_again_q;
    assign bus.cursor_row = row_q;
    assign bus.cursor_col = col_q;
    assign bus.revealed   = revealed_q;

endmodule

// File: tb/tb_move_judge.sv
// ----------------------------------------------------------------------------
// tb_move_judge
//   Self-checking bench for move_judge. A behavioural board model predicts
//   cond, cursor, revealed (and flagged when MOVE_JUDGE_FLAG_EN is defined)
//   for every driven action; the prediction is queued when the stimulus is
//   applied and compared once the judge has had time to respond.
// ----------------------------------------------------------------------------
module tb_move_judge;
    import ms_pkg::*;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int CELLS = ROWS * COLS;

    localparam int B_REV   = 1;
    localparam int B_FLAG  = 2;
    localparam int B_UP    = 4;
    localparam int B_DOWN  = 8;
    localparam int B_LEFT  = 16;
    localparam int B_RIGHT = 32;

`ifdef MOVE_JUDGE_FLAG_EN
    localparam bit FLAG_EN = 1'b1;
`else
    localparam bit FLAG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    move_judge_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    move_judge #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- board model ----------------
    logic [63:0] m_mines, m_rev, m_flag;
    int          m_row, m_col, m_safe;
    logic [1:0]  m_cond;
    bit          m_active;

    typedef struct {
        string       tag;
        logic [1:0]  cond;
        logic [63:0] revealed;
        logic [63:0] flagged;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        play_again;
    } exp_t;

    exp_t sb_q[$];

    function automatic void push_exp(input string tag, input logic pa);
        exp_t e;
        e.tag        = tag;
        e.cond       = m_cond;
        e.revealed   = m_rev;
        e.flagged    = m_flag;
        e.row        = 3'(m_row);
        e.col        = 3'(m_col);
        e.play_again = pa;
        sb_q.push_back(e);
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        check({e.tag, ".cond"},       64'(bus.cond),       64'(e.cond));
        check({e.tag, ".revealed"},   bus.revealed,        e.revealed);
        check({e.tag, ".row"},        64'(bus.cursor_row), 64'(e.row));
        check({e.tag, ".col"},        64'(bus.cursor_col), 64'(e.col));
        check({e.tag, ".play_again"}, 64'(bus.play_again), 64'(e.play_again));
`ifdef MOVE_JUDGE_FLAG_EN
        check({e.tag, ".flagged"},    bus.flagged,         e.flagged);
`endif
    endtask

    function automatic void model_apply(input int mask);
        int idx;
        idx = m_row * COLS + m_col;
        if (!m_active) return;
        if ((mask & B_REV) != 0) begin
            if (FLAG_EN && m_flag[idx]) begin
                // reveal on a flagged cell is ignored
            end else if (m_mines[idx]) begin
                m_cond   = COND_LOSE;
                m_active = 1'b0;
            end else if (!m_rev[idx]) begin
                m_rev[idx] = 1'b1;
                m_safe--;
                if (m_safe == 0 || m_mines == 64'd0) begin
                    m_cond   = COND_WIN;
                    m_active = 1'b0;
                end
            end
        end else if (FLAG_EN && (mask & B_FLAG) != 0) begin
            if (!m_rev[idx]) m_flag[idx] = ~m_flag[idx];
        end else if ((mask & B_UP) != 0) begin
            if (m_row > 0) m_row--;
        end else if ((mask & B_DOWN) != 0) begin
            if (m_row < ROWS - 1) m_row++;
        end else if ((mask & B_LEFT) != 0) begin
            if (m_col > 0) m_col--;
        end else if ((mask & B_RIGHT) != 0) begin
            if (m_col < COLS - 1) m_col++;
        end
    endfunction

    function automatic void model_reset();
        m_mines  = '0;
        m_rev    = '0;
        m_flag   = '0;
        m_row    = 0;
        m_col    = 0;
        m_safe   = 0;
        m_cond   = COND_PLAY;
        m_active = 1'b0;
    endfunction

    // ---------------- stimulus helpers ----------------
    int pa_seen = 0;
    always @(negedge clk) if (bus.play_again === 1'b1) pa_seen++;

    task automatic set_btns(input int mask);
        bus.btn_reveal = ((mask & B_REV)   != 0);
        bus.btn_up     = ((mask & B_UP)    != 0);
        bus.btn_down   = ((mask & B_DOWN)  != 0);
        bus.btn_left   = ((mask & B_LEFT)  != 0);
        bus.btn_right  = ((mask & B_RIGHT) != 0);
`ifdef MOVE_JUDGE_FLAG_EN
        bus.btn_flag   = ((mask & B_FLAG)  != 0);
`endif
    endtask

    // Press for one cycle, release, then allow the reveal pipeline to settle
    // (three rising edges after the press) before comparing.
    task automatic act(input int mask, input string tag);
        model_apply(mask);
        push_exp(tag, 1'b0);
        set_btns(mask);
        @(negedge clk);
        set_btns(0);
        @(negedge clk);
        @(negedge clk);
        compare_out();
    endtask

    task automatic start_game(input logic [63:0] map, input string tag);
        bus.mine_map = map;
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        @(negedge clk);
        m_mines  = map;
        m_rev    = '0;
        m_flag   = '0;
        m_row    = 0;
        m_col    = 0;
        m_safe   = CELLS - $countones(map);
        m_cond   = COND_PLAY;
        m_active = 1'b1;
        push_exp(tag, 1'b0);
        compare_out();
    endtask

    task automatic reset_mid(input string tag);
        #2 rst = 1'b0;
        model_reset();
        push_exp(tag, 1'b0);
        #1 compare_out();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int pa0;
        int idx;

        bus.new_game  = 1'b0;
        bus.mine_map  = '0;
        bus.game_done = 1'b0;
        set_btns(0);
        model_reset();

        @(negedge clk);
        @(negedge clk);
        push_exp("reset", 1'b0);
        compare_out();
        rst = 1'b1;
        @(negedge clk);

        // Mine at cell 0: reveal neighbours safely, then async reset mid-game.
        start_game(64'h1, "t2_load");
        act(B_RIGHT, "t2_right");
        act(B_REV,   "t2_rev_cell1");
        act(B_DOWN,  "t2_down");
        act(B_REV,   "t2_rev_cell9");
        reset_mid("t1_reset_mid");

        // Reveal the mine at (0,0) -> lose.
        start_game(64'h1, "t2_load2");
        act(B_REV, "t2_rev_mine");

        // OVER: reveal without game_done is ignored, board frozen.
        pa0 = pa_seen;
        act(B_REV,   "t5_rev_not_done");
        check("t5_no_play_again", 64'(pa_seen), 64'(pa0));
        act(B_RIGHT, "t5_frozen_cursor");

        // OVER with game_done: one-cycle play_again, cond cleared, back to IDLE.
        bus.game_done  = 1'b1;
        bus.btn_reveal = 1'b1;
        @(negedge clk);
        m_cond = COND_PLAY;
        push_exp("t5_pa_high", 1'b1);
        compare_out();
        bus.btn_reveal = 1'b0;
        @(negedge clk);
        push_exp("t5_pa_low", 1'b0);
        compare_out();
        bus.game_done = 1'b0;
        @(negedge clk);
        check("t5_pa_pulse_count", 64'(pa_seen), 64'(pa0 + 1));
        act(B_DOWN, "t5_idle_ignores_down");
        act(B_REV,  "t5_idle_ignores_reveal");

        // Cursor saturation and priority.
        start_game(64'h8000_0000_0000_0000, "t4_load");
        for (int i = 0; i < 3; i++) act(B_LEFT, $sformatf("t4_left%0d", i));
        for (int i = 0; i < 3; i++) act(B_UP,   $sformatf("t4_up%0d", i));
        for (int i = 0; i < 9; i++) act(B_DOWN, $sformatf("t4_down%0d", i));
        for (int i = 0; i < 9; i++) act(B_RIGHT, $sformatf("t4_right%0d", i));
        act(B_UP | B_LEFT,    "t4_prio_up_over_left");
        act(B_DOWN | B_RIGHT, "t4_prio_down_over_right");
        act(B_LEFT | B_RIGHT, "t4_prio_left_over_right");
        act(B_REV | B_UP,     "t4_prio_reveal_over_up");

        // Restart from WAIT_MOVE; mine at 63, sweep every safe cell.
        start_game(64'h8000_0000_0000_0000, "t3_load");
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < COLS; k++) begin
                int c;
                c   = (r % 2 == 0) ? k : COLS - 1 - k;
                idx = r * COLS + c;
                if (idx != 63) begin
                    act(B_REV, $sformatf("t3_rev%0d", idx));
                    if (idx == 0 || idx == 57) act(B_REV, $sformatf("t3_rerev%0d", idx));
                end
                if (k < COLS - 1) act((r % 2 == 0) ? B_RIGHT : B_LEFT, $sformatf("t3_mv%0d", idx));
            end
            if (r < ROWS - 1) act(B_DOWN, $sformatf("t3_down%0d", r));
        end
        check("t3_final_cond_win", 64'(bus.cond), 64'(COND_WIN));
        check("t3_revealed_count", 64'($countones(bus.revealed)), 64'd63);

        // Mine-free board: first safe reveal wins. All-mine board: first reveal loses.
        start_game(64'h0, "mfree_load");
        act(B_REV, "mfree_first_reveal");
        start_game(64'hFFFF_FFFF_FFFF_FFFF, "allmine_load");
        act(B_REV, "allmine_first_reveal");

`ifdef MOVE_JUDGE_FLAG_EN
        start_game(64'h8000_0000_0000_0000, "t6_load");
        for (int i = 0; i < 5; i++) act(B_RIGHT, $sformatf("t6_right%0d", i));
        act(B_FLAG,         "t6_flag5");
        act(B_REV,          "t6_rev_flagged5");
        act(B_FLAG,         "t6_unflag5");
        act(B_REV,          "t6_rev5");
        act(B_FLAG,         "t6_flag_revealed5");
        act(B_REV | B_FLAG, "t6_prio_reveal_over_flag");
`endif

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
